div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  32  dividend (rs), sampled only on the accepting edge.
REQ-005 b  input  32  divisor (rt), sampled only on the accepting edge.
REQ-006 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled only on the accepting edge.
REQ-007 start  input  1  request a new division.
REQ-008 annul  input  1  flush/exception cancel of the in-flight or requested operation.
REQ-009 result  output  64  {hi = remainder[63:32], lo = quotient[31:0]}; feeds the HILO register read by the ALU.
REQ-010 ready  output  1  result valid, a one-cycle pulse.
REQ-011 busy  output  1  pipeline stall request.

Function
REQ-012 The FSM SHALL have states IDLE, ZERO, RUN, DONE, plus a 6-bit iteration counter.
REQ-013 Accept condition, in IDLE: start=1 and annul=0.
- On the accepting edge: latch a, b and signed_div.
- If b==0, go to ZERO; otherwise go to RUN with the counter cleared.
REQ-014 In IDLE with start=0, or start=1 with annul=1, state SHALL stay IDLE.
REQ-015 RUN performs one radix-2 restoring shift-subtract step per edge on 32-bit magnitudes with a 33-bit partial remainder.
- After the 32nd RUN edge, state goes to DONE.
REQ-016 ZERO goes to DONE on the next edge.
REQ-017 DONE goes to IDLE on the next edge, regardless of start; a start seen in DONE is ignored.
REQ-018 Latency: the accepting edge is E0.
- Nonzero divisor: ready=1 exactly during the cycle after E32.
- Zero divisor: ready=1 during the cycle after E1.
REQ-019 ready SHALL be 1 only in DONE and SHALL be registered, with no combinational path from inputs.
REQ-020 busy = (IDLE & start & ~annul) | RUN | ZERO. busy SHALL be 0 in DONE so the pipeline advances with the result.
REQ-021 start is ignored while in RUN or ZERO; operands are not re-sampled.
REQ-022 Signed mode sign rules:
- Operands are converted to magnitudes before iterating.
- Quotient sign = a[31]^b[31]; remainder sign = a[31]; negation applied when entering DONE.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no trap or flag.
REQ-023 Unsigned mode: no sign handling; all 32 bits are magnitude.
REQ-024 Divide by zero (either mode): result = {a, 32'hFFFFFFFF}.
REQ-025 result SHALL update only on the edge entering DONE and SHALL hold that value until the next DONE entry; intermediate iteration state is never visible on result.
REQ-026 annul=1 in RUN or ZERO:
- Next edge goes to IDLE, no ready pulse, result unchanged.
- A new start SHALL be accepted on the following edge.
REQ-027 annul=1 in DONE SHALL NOT suppress the ready pulse already being presented.
REQ-028 The counter SHALL never wrap; it is cleared on every accept and on every exit from RUN.

Reset
REQ-029 While rst=1, immediately and independent of clk: state=IDLE, counter=0, result=64'h0, ready=0, busy=0.
REQ-030 rst asserted in any state, including mid-RUN, SHALL abort the operation with no ready pulse.
REQ-031 After rst deasserts, the first accept is possible on the first rising edge.

Verification
REQ-032 Unsigned basic: a=100, b=7, signed_div=0, start pulse -> ready in the cycle after E32, result hi=2, lo=14; busy high from the start cycle through the E32 cycle.
REQ-033 Signed negative dividend: a=0xFFFFFFF9 (-7), b=2, signed_div=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Signed overflow case: a=0x80000000, b=0xFFFFFFFF, signed_div=1 -> lo=0x80000000, hi=0x00000000, latency 33 edges.
REQ-035 Divide by zero: a=0x12345678, b=0 -> ready in the cycle after E1, result={0x12345678, 0xFFFFFFFF}.
REQ-036 Annul mid-run: annul=1 after E10, following a previous result R -> no ready, state IDLE, result==R; a start on the next edge completes normally.
REQ-037 Async reset mid-run: rst pulsed between edges at E15 -> result=0, ready=0, busy=0 before the next edge; a fresh division after release is correct.

Source files
------------

// File: rtl/div_unit.sv
// Iterative 32-bit divider for the HILO unit: radix-2 restoring, one quotient bit per clock.
// Result is {remainder, quotient}; a zero divisor short-circuits to {a, all-ones}.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_div,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StZero, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        accept;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, rem_sub;
    logic        fits;
    logic [31:0] step_q, step_r, q_fix, r_fix;

    assign accept = start & ~annul;
    assign a_mag  = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign b_mag  = (signed_div && b[31]) ? (~b + 32'd1) : b;

    // quo_q shifts dividend bits out of the top and quotient bits in at the bottom
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign fits    = ~rem_sub[32];
    assign step_q  = {quo_q[30:0], fits};
    assign step_r  = fits ? rem_sub[31:0] : rem_sh[31:0];
    assign q_fix   = q_neg_q ? (~step_q + 32'd1) : step_q;
    assign r_fix   = r_neg_q ? (~step_r + 32'd1) : step_r;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        ready_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dvs_d   = b_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = signed_div & (a[31] ^ b[31]);
                    r_neg_d = signed_div & a[31];
                    if (b == 32'd0) begin
                        quo_d   = a;
                        state_d = StZero;
                    end else begin
                        quo_d   = a_mag;
                        state_d = StRun;
                    end
                end
            end
            StZero: begin
                if (annul) begin
                    state_d = StIdle;
                end else begin
                    state_d  = StDone;
                    ready_d  = 1'b1;
                    result_d = {quo_q, 32'hFFFF_FFFF};
                end
            end
            StRun: begin
                if (annul) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    quo_d = step_q;
                    rem_d = step_r;
                    if (cnt_q == 6'd31) begin
                        cnt_d    = '0;
                        state_d  = StDone;
                        ready_d  = 1'b1;
                        result_d = {r_fix, q_fix};
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    // Gated by rst so a held start cannot raise a stall while in reset
    assign busy   = ~rst & (((state_q == StIdle) & accept) | (state_q == StRun) |
                            (state_q == StZero));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {result, ready cycle},
// a negedge monitor pops and compares on every ready pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        signed_div, start, annul;
    logic [63:0] result;
    logic        ready, busy;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_res = 64'd0;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .signed_div(signed_div),
        .start     (start),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: actual ready=1 result=%h required no pulse", result);
            end else begin
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic drive_start(input logic [31:0] av, input logic [31:0] bv, input logic s);
        a          = av;
        b          = bv;
        signed_div = s;
        start      = 1'b1;
    endtask

    // Call just after a rising edge; the next edge is the accepting edge E0
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s,
                         input logic [63:0] res, input int unsigned lat);
        drive_start(av, bv, s);
        exp_q.push_back('{res: res, cyc: cyc + 1 + lat});
        last_res = res;
        #1 chk("busy_on_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            n++;
            if (!ready) chk("busy_while_running", 64'(busy), 64'd1);
            if (n > 80) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: actual no ready after %0d cycles required ready", n);
                exp_q.delete();
            end
        end
    endtask

    task automatic run(input logic [31:0] av, input logic [31:0] bv, input logic s,
                       input logic [63:0] res, input int unsigned lat);
        @(posedge clk);
        #1 issue(av, bv, s, res, lat);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        rst = 1'b1; a = 32'hFFFF_FFFF; b = 32'd1; signed_div = 1'b0; start = 1'b1; annul = 1'b0;
        #12;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        #1 rst = 1'b0;
        start = 1'b0;
        // First accept on the first edge after release
        issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 32);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        run(32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 32);
        run(32'h1234_5678, 32'd0,         1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 1);
        run(32'hFFFF_FFFF, 32'h10,        1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, 32);
        run(32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 32);
        run(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 32);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 32);
        run(32'hFFFF_FF00, 32'd0,         1'b1, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);
        run(32'd5,         32'd9,         1'b0, {32'h0000_0005, 32'h0000_0000}, 32);

        // Annul while in ZERO
        @(posedge clk);
        #1 drive_start(32'h55, 32'd0, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul_zero_busy", 64'(busy), 64'd0);
        chk("annul_zero_result", result, last_res);
        repeat (3) @(posedge clk);

        // Annul after E10, then restart on the very next edge
        #1 drive_start(32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul_run_busy", 64'(busy), 64'd0);
        chk("annul_run_result", result, last_res);
        issue(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 32);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Async reset pulsed between edges after E15
        @(posedge clk);
        #1 drive_start(32'd50, 32'd5, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_reset_result", result, 64'd0);
        chk("midrun_reset_ready", 64'(ready), 64'd0);
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        #1 rst = 1'b0;
        last_res = 64'd0;
        run(32'hDEAD_BEEF, 32'h100, 1'b0, {32'h0000_00EF, 32'h00DE_ADBE}, 32);

        // Annul during DONE must not suppress the ready pulse
        @(posedge clk);
        #1 t = cyc + 33;
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 32);
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
